relu_maxpool2: RTL
==================

# relu_maxpool2

Downstream stage of the second 3x3 convolution layer in the CNN digit-classification pipeline. It consumes the convolution's raster-ordered stream of signed accumulator values, qualified by a one-cycle-per-pixel enable. It applies ReLU, 2x2 max pooling with stride 2, and requantisation by arithmetic right shift with saturation. The result is a (ROWS/2)x(COLS/2) stream narrow enough to feed the next convolution or the dense layer.

## Interface
- W3, 21: input sample width (signed), matches convolution accumulator output
- WO, 9: output sample width (signed; results are always >= 0)
- ROWS, 14: input rows per frame (must be even)
- COLS, 14: input columns per frame (must be even)
- SHIFT, 8: requantisation right shift applied after pooling
- clk  input  1  sole clock; all state on rising edge
- rst  input  1  asynchronous, active-low reset; clears all state immediately
- inp  input  W3  signed input sample, valid when En_in=1
- En_in  input  1  input qualifier; one pixel per cycle while high; gaps allowed
- oup  output  WO  pooled, rectified, requantised sample
- En  output  1  high for exactly one cycle per valid oup
- frame_done  output  1  one-cycle pulse coincident with the last oup of a frame

## Operation
- Counters: col (0..COLS-1) and row (0..ROWS-1). They advance only on cycles with En_in=1. col wraps to 0 at COLS-1 and increments row. row wraps to 0 at ROWS-1 (end of frame).
- Horizontal stage:
  - col even: latch inp into hold register h.
  - col odd: hmax = max(h, inp), signed compare.
- Line buffer: COLS/2 entries, each W3 wide, indexed by col>>1.
  - Even row, odd col: write hmax to linebuf[col>>1]. No output.
  - Odd row, odd col: pmax = max(linebuf[col>>1], hmax). This is a pool completion.
- Post-processing on pool completion:
  - r = (pmax < 0) ? 0 : pmax.
  - q = r >>> SHIFT (arithmetic shift, truncation toward zero since r >= 0).
  - oup = (q > 2^(WO-1)-1) ? 2^(WO-1)-1 : q[WO-1:0].
- Frame completion: the pool completion at row=ROWS-1, col=COLS-1 also asserts frame_done with that output.
- State: implicit in row parity and col parity; no other FSM states. Each frame is processed identically; frames may be back-to-back with no gap cycle.
- Line-buffer entries are never cleared between frames. They are always rewritten on the even row before they are read.
- En_in=0 cycles: no counter, register or buffer change. En and frame_done drop to 0 on the following edge.

## Timing
- Reset values: oup=0, En=0, frame_done=0, col=0, row=0, h=0.
- Line-buffer contents are don't-care after reset.
- Latency: oup/En/frame_done are registered and appear on the rising edge after the clock edge that samples the completing pixel (odd row, odd col).
- Throughput: one input per cycle. Output rate is at most one per 2 input cycles within odd rows; there are no outputs during even rows.
- Output count per frame: (ROWS/2)*(COLS/2), which is 49 for the defaults.
- oup holds its last value when En=0. Consumers use En only.
- Reset asserted mid-frame: all outputs are forced to reset values asynchronously. After release, the first En_in sample is treated as row 0, col 0. The partial frame is discarded.
- Reset released while En_in=1: sampling starts on the first rising edge after release.
- Width rule: all compares are W3-bit signed. No intermediate widening is required.

## Test plan
- Ramp frame: inp = row*COLS+col (0..195), En_in held high with defaults and SHIFT=0, WO wide enough to avoid saturation (parameter override WO=12) -> 49 outputs. The first is 15 (max of 0,1,14,15), the last is 195. frame_done coincides with output 49. Each En is one cycle after its odd/odd input.
- ReLU: every pixel = -1000 for one frame -> 49 outputs all 0, En pulses still present.
- Saturation/shift: one 2x2 window contains 200000, rest 0, SHIFT=8, WO=9 -> that output = 255 (200000>>8 = 781 saturates), all others 0. A window max of 5120 -> 20.
- Gapped input: ramp frame with En_in toggling 1,0,1,0 -> identical oup sequence to the first test. En never asserted on a cycle not preceded by an En_in=1 completion.
- Back-to-back frames: two ramp frames with no gap, second offset by +1000 -> second frame's first output 1015. frame_done pulses exactly twice. No stale line-buffer data appears.
- Reset mid-frame: assert rst low after 100 inputs, release, send a full ramp frame -> outputs and frame_done match the first test exactly. oup/En/frame_done read 0 during reset.

Source files
------------

// File: rtl/relu_maxpool2_if.sv
// Stream bundle for relu_maxpool2: raster input samples in, pooled samples out.
// slave is the pooling stage's view; master is the producer/consumer side.
interface relu_maxpool2_if #(
   parameter int W3 = 21,
   parameter int WO = 9
);
   logic signed [W3-1:0] inp;
   logic                 En_in;
   logic signed [WO-1:0] oup;
   logic                 En;
   logic                 frame_done;

   modport master (output inp, En_in, input  oup, En, frame_done);
   modport slave  (input  inp, En_in, output oup, En, frame_done);
endinterface

// File: rtl/relu_maxpool2.sv
// ReLU + 2x2/stride-2 max pool + shift/saturate requantisation; outputs registered one edge after the completing pixel.
// No backpressure: accepts one pixel per En_in cycle, gaps freeze all state.
module relu_maxpool2 #(
   parameter int W3    = 21,
   parameter int WO    = 9,
   parameter int ROWS  = 14,
   parameter int COLS  = 14,
   parameter int SHIFT = 8
)(
   input  logic          clk,
   input  logic          rst,
   relu_maxpool2_if.slave io
);
   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);
   localparam int LW = $clog2(COLS / 2);
   localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
   localparam logic [CW-1:0] COL_ONE = CW'(1);
   localparam logic [RW-1:0] ROW_ONE = RW'(1);
   localparam logic signed [W3-1:0] OMAX = W3'((2 ** (WO - 1)) - 1);

   logic [CW-1:0]        col_q, col_d;
   logic [RW-1:0]        row_q, row_d;
   logic signed [W3-1:0] h_q, h_d;
   logic signed [WO-1:0] oup_q, oup_d;
   logic                 en_q, en_d;
   logic                 fd_q, fd_d;

   logic signed [W3-1:0] lb_q [COLS/2];
   logic [LW-1:0]        lb_idx;
   logic                 lb_we;

   logic signed [W3-1:0] lb_rd, hmax, pmax, relu, shft;
   logic signed [WO-1:0] sat;

   assign lb_idx = LW'(col_q >> 1);
   assign lb_rd  = lb_q[lb_idx];

   always_comb begin
      hmax = (io.inp > h_q) ? io.inp : h_q;
      pmax = (lb_rd > hmax) ? lb_rd : hmax;
      relu = pmax[W3-1] ? '0 : pmax;
      shft = relu >>> SHIFT;
      sat  = (shft > OMAX) ? OMAX[WO-1:0] : shft[WO-1:0];
   end

   // Row/col parity alone decides what each accepted pixel does.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      h_d   = h_q;
      oup_d = oup_q;
      en_d  = 1'b0;
      fd_d  = 1'b0;
      lb_we = 1'b0;
      if (io.En_in) begin
         if (col_q == COL_MAX) begin
            col_d = '0;
            row_d = (row_q == ROW_MAX) ? '0 : row_q + ROW_ONE;
         end else begin
            col_d = col_q + COL_ONE;
         end
         if (!col_q[0]) begin
            h_d = io.inp;
         end else if (!row_q[0]) begin
            lb_we = 1'b1;
         end else begin
            en_d  = 1'b1;
            oup_d = sat;
            fd_d  = (row_q == ROW_MAX) && (col_q == COL_MAX);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_q <= '0;
         row_q <= '0;
         h_q   <= '0;
         oup_q <= '0;
         en_q  <= 1'b0;
         fd_q  <= 1'b0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
         h_q   <= h_d;
         oup_q <= oup_d;
         en_q  <= en_d;
         fd_q  <= fd_d;
      end
   end

   // Entries are always rewritten on the even row before use, so no reset.
   always_ff @(posedge clk) begin
      if (lb_we) lb_q[lb_idx] <= hmax;
   end

   assign io.oup        = oup_q;
   assign io.En         = en_q;
   assign io.frame_done = fd_q;
endmodule
